// File: rtl/tis_node_ctrl.sv
// Instruction sequencer for one TIS-100 execution node: decodes the 18-bit word,
// runs blocking neighbour reads/writes and pulses the execution-path control set.
module tis_node_ctrl #(
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [17:0]        instr,
    input  logic [DATA_W-1:0]  acc_cond,
    input  logic [DATA_W-1:0]  in_data0,
    input  logic [DATA_W-1:0]  in_data1,
    input  logic [DATA_W-1:0]  in_data2,
    input  logic [DATA_W-1:0]  in_data3,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ack,
    output logic [DATA_W-1:0]  out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [DATA_W-1:0]  mov_data,
    output logic [1:0]         alu_sel,
    output logic               swp_active,
    output logic               en_bak,
    output logic               jmp_instr,
    output logic               jmp_uncond,
    output logic [1:0]         jmp_cond,
    output logic               pc_en,
    output logic               busy_stall,
    output logic [STALL_W-1:0] stall_cycles
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_WRITE,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [17:0]        ir_q, ir_d;
    logic [DATA_W-1:0]  mov_q, mov_d;
    logic [DATA_W-1:0]  rd_sel;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [3:0]         opc;
    logic [2:0]         src;
    logic [2:0]         dst;
    logic               src_port;
    logic               wr_port;
    logic               cond_true;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    assign opc      = ir_q[3:0];
    assign src      = ir_q[6:4];
    assign dst      = ir_q[9:7];
    assign src_port = ~src[2];
    assign wr_port  = (opc == 4'd1) && ~dst[2];

    always_comb begin
        unique case (src[1:0])
            2'd0:    rd_sel = in_data0;
            2'd1:    rd_sel = in_data1;
            2'd2:    rd_sel = in_data2;
            default: rd_sel = in_data3;
        endcase
    end

    // Jcc opcodes 8..11 map their low two bits straight onto EZ/NZ/GZ/LZ
    always_comb begin
        unique case (opc[1:0])
            2'd0:    cond_true = ~|acc_cond;
            2'd1:    cond_true = |acc_cond;
            2'd2:    cond_true = ~acc_cond[DATA_W-1] && (|acc_cond);
            default: cond_true = acc_cond[DATA_W-1];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        mov_d      = mov_q;
        in_ack     = '0;
        out_valid  = '0;
        out_data   = '0;
        alu_sel    = 2'b00;
        swp_active = 1'b0;
        en_bak     = 1'b0;
        jmp_instr  = 1'b0;
        jmp_uncond = 1'b0;
        jmp_cond   = 2'b00;
        pc_en      = 1'b0;
        busy_stall = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (src_port) begin
                    state_d = S_READ;
                end else begin
                    unique case (src)
                        3'd4:    mov_d = acc_cond;
                        3'd6:    mov_d = DATA_W'(ir_q[17:10]);
                        default: mov_d = '0;
                    endcase
                    state_d = wr_port ? S_WRITE : S_COMMIT;
                end
            end
            S_READ: begin
                busy_stall = 1'b1;
                if (in_valid[src[1:0]]) begin
                    mov_d            = rd_sel;
                    in_ack[src[1:0]] = 1'b1;
                    state_d          = wr_port ? S_WRITE : S_COMMIT;
                end
            end
            S_WRITE: begin
                busy_stall          = 1'b1;
                out_data            = mov_q;
                out_valid[dst[1:0]] = 1'b1;
                if (out_ready[dst[1:0]]) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_FETCH;
                pc_en   = 1'b1;
                unique case (opc)
                    4'd2: swp_active = 1'b1;
                    4'd3: en_bak     = 1'b1;
                    4'd4: alu_sel    = 2'b01;
                    4'd5: alu_sel    = 2'b10;
                    4'd6: alu_sel    = 2'b11;
                    4'd7: begin
                        jmp_uncond = 1'b1;
                        pc_en      = 1'b0;
                    end
                    4'd8, 4'd9, 4'd10, 4'd11: begin
                        jmp_instr = 1'b1;
                        jmp_cond  = opc[1:0];
                        pc_en     = ~cond_true;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
        stall_d = busy_stall ? sat_inc(stall_q) : stall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            mov_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            mov_q   <= mov_d;
            stall_q <= stall_d;
        end
    end

    assign mov_data     = mov_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_tis_node_ctrl.sv
// Bench for tis_node_ctrl: per-instruction cycle timelines built from the
// instruction rules, replayed against the DUT with randomized noise and data.
module tb_tis_node_ctrl;
    localparam int DW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [17:0]   instr;
    logic [DW-1:0] acc_cond, in_data0, in_data1, in_data2, in_data3;
    logic [3:0]    in_valid, in_ack, out_valid, out_ready;
    logic [DW-1:0] out_data, mov_data;
    logic [1:0]    alu_sel, jmp_cond;
    logic          swp_active, en_bak, jmp_instr, jmp_uncond, pc_en, busy_stall;
    logic [SW-1:0] stall_cycles;

    tis_node_ctrl #(.DATA_W(DW), .STALL_W(SW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .acc_cond(acc_cond),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_valid(in_valid), .in_ack(in_ack), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .mov_data(mov_data), .alu_sel(alu_sel),
        .swp_active(swp_active), .en_bak(en_bak), .jmp_instr(jmp_instr),
        .jmp_uncond(jmp_uncond), .jmp_cond(jmp_cond), .pc_en(pc_en),
        .busy_stall(busy_stall), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] instr;
        logic [7:0]  acc;
        logic [3:0]  iv;
        logic [3:0]  rdy;
        logic [31:0] din;
        logic [3:0]  ack;
        logic [3:0]  ov;
        logic [7:0]  od;
        logic [7:0]  mov;
        logic [1:0]  alu;
        logic        swp, bak, ji, ju;
        logic [1:0]  jc;
        logic        pc, busy;
        logic [3:0]  stall;
    } rec_t;

    rec_t       q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_mov;
    int         m_stall;

    int         run_cyc, pc_cyc, n_ack1, n_ov3;
    logic       pc_seen, ji_seen, busy_seen;
    logic [1:0] jc_seen;
    logic [7:0] mov_at_pc, od_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] sat(input int v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    function automatic rec_t blank(input logic [7:0] acc);
        rec_t r;
        r.instr = 18'($urandom);
        r.acc   = acc;
        r.iv    = 4'($urandom);
        r.rdy   = 4'($urandom);
        r.din   = $urandom;
        r.ack   = '0; r.ov = '0; r.od = '0; r.alu = '0; r.jc = '0;
        r.swp   = 0; r.bak = 0; r.ji = 0; r.ju = 0; r.pc = 0; r.busy = 0;
        r.mov   = m_mov;
        r.stall = sat(m_stall);
        return r;
    endfunction

    // Timeline of one instruction: FETCH, DECODE, nr+1 READ, nw+1 WRITE, COMMIT
    task automatic gen(input logic [17:0] ins, input logic [7:0] acc,
                       input int nr, input int nw, input logic [7:0] rd);
        logic [3:0] op;
        logic [2:0] src, dst;
        logic       rdp, wrp, taken;
        int         sp, dp, sa;
        rec_t       r;
        op  = ins[3:0];
        src = ins[6:4];
        dst = ins[9:7];
        sp  = int'(src[1:0]);
        dp  = int'(dst[1:0]);
        rdp = (src < 3'd4);
        wrp = (op == 4'd1) && (dst < 3'd4);
        r = blank(acc); r.instr = ins; q.push_back(r);
        r = blank(acc); q.push_back(r);
        if (!rdp) m_mov = (src == 3'd4) ? acc : (src == 3'd6) ? ins[17:10] : 8'h00;
        if (rdp) begin
            for (int k = 0; k <= nr; k++) begin
                r = blank(acc);
                r.busy = 1;
                r.iv[sp] = (k == nr);
                if (k == nr) begin
                    r.din[8*sp +: 8] = rd;
                    r.ack[sp] = 1'b1;
                end
                q.push_back(r);
                m_stall++;
            end
            m_mov = rd;
        end
        if (wrp) begin
            for (int k = 0; k <= nw; k++) begin
                r = blank(acc);
                r.busy = 1;
                r.rdy[dp] = (k == nw);
                r.ov[dp] = 1'b1;
                r.od = m_mov;
                q.push_back(r);
                m_stall++;
            end
        end
        r = blank(acc);
        sa = $signed(acc);
        case (op[1:0])
            2'd0:    taken = (sa == 0);
            2'd1:    taken = (sa != 0);
            2'd2:    taken = (sa > 0);
            default: taken = (sa < 0);
        endcase
        r.pc = 1;
        case (op)
            4'd2: r.swp = 1;
            4'd3: r.bak = 1;
            4'd4: r.alu = 2'b01;
            4'd5: r.alu = 2'b10;
            4'd6: r.alu = 2'b11;
            4'd7: begin r.ju = 1; r.pc = 0; end
            4'd8, 4'd9, 4'd10, 4'd11: begin r.ji = 1; r.jc = op[1:0]; r.pc = !taken; end
            default: ;
        endcase
        q.push_back(r);
    endtask

    task automatic clear_obs();
        run_cyc = 0; pc_cyc = 0; n_ack1 = 0; n_ov3 = 0;
        pc_seen = 0; ji_seen = 0; busy_seen = 0; jc_seen = 2'b11;
        mov_at_pc = 8'h00; od_seen = 8'h00;
    endtask

    task automatic compare(input rec_t r);
        chk("ports", 64'({in_ack, out_valid, out_data}), 64'({r.ack, r.ov, r.od}));
        chk("mov_data", 64'(mov_data), 64'(r.mov));
        chk("ctrl", 64'({alu_sel, swp_active, en_bak, jmp_instr, jmp_uncond, jmp_cond, pc_en}),
            64'({r.alu, r.swp, r.bak, r.ji, r.ju, r.jc, r.pc}));
        chk("stall", 64'({busy_stall, stall_cycles}), 64'({r.busy, r.stall}));
    endtask

    // Entered and left at posedge+1, i.e. with a fresh cycle just started
    task automatic run_n(input int n);
        rec_t r;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            instr = r.instr; acc_cond = r.acc; in_valid = r.iv; out_ready = r.rdy;
            {in_data3, in_data2, in_data1, in_data0} = r.din;
            @(negedge clk);
            compare(r);
            run_cyc++;
            if (pc_en) begin pc_seen = 1; pc_cyc = run_cyc; mov_at_pc = mov_data; end
            if (jmp_instr) begin ji_seen = 1; jc_seen = jmp_cond; end
            if (in_ack[1]) n_ack1++;
            if (out_valid[3]) begin n_ov3++; od_seen = out_data; end
            if (busy_stall) busy_seen = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    initial begin
        logic [3:0] op;
        logic [2:0] src, dst;
        logic [7:0] acc;
        reset = 1; instr = '0; acc_cond = '0; in_valid = '0; out_ready = '0;
        in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
        m_mov = 8'h00; m_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 64'({in_ack, out_valid, out_data, mov_data, alu_sel, swp_active, en_bak,
                               jmp_instr, jmp_uncond, jmp_cond, pc_en, busy_stall}), 64'(0));
        chk("reset_stall", 64'(stall_cycles), 64'(0));
        @(posedge clk); #1;
        reset = 0;

        clear_obs();
        gen({8'h2A, 3'd4, 3'd6, 4'd1}, 8'h77, 0, 0, 8'h00);
        run_all();
        chk("t1_commit_cycle", 64'(pc_cyc), 64'(3));
        chk("t1_mov_data", 64'(mov_at_pc), 64'(8'h2A));
        chk("t1_busy_seen", 64'(busy_seen), 64'(0));

        clear_obs();
        gen({8'h00, 3'd3, 3'd1, 4'd1}, 8'h10, 4, 2, 8'h5C);
        run_all();
        chk("t2_ack1_pulses", 64'(n_ack1), 64'(1));
        chk("t2_ov3_cycles", 64'(n_ov3), 64'(3));
        chk("t2_out_data", 64'(od_seen), 64'(8'h5C));
        chk("t2_stall", 64'(stall_cycles), 64'(8));

        clear_obs();
        gen({8'h00, 3'd5, 3'd5, 4'd8}, 8'h00, 0, 0, 8'h00);
        run_all();
        chk("jez0_ji", 64'({ji_seen, jc_seen}), 64'(3'b100));
        chk("jez0_pc", 64'(pc_seen), 64'(0));
        clear_obs();
        gen({8'h00, 3'd5, 3'd5, 4'd8}, 8'h05, 0, 0, 8'h00);
        run_all();
        chk("jez5_pc", 64'(pc_seen), 64'(1));
        clear_obs();
        gen({8'h00, 3'd5, 3'd5, 4'd10}, 8'h80, 0, 0, 8'h00);
        run_all();
        chk("jgz80_pc", 64'(pc_seen), 64'(1));
        clear_obs();
        gen({8'h00, 3'd5, 3'd5, 4'd11}, 8'h80, 0, 0, 8'h00);
        run_all();
        chk("jlz80_pc", 64'(pc_seen), 64'(0));

        clear_obs();
        gen({8'h00, 3'd4, 3'd2, 4'd1}, 8'h01, 19, 0, 8'h33);
        run_all();
        chk("sat_stall", 64'(stall_cycles), 64'(15));

        // Asynchronous reset in the middle of a stalled write
        clear_obs();
        gen({8'h11, 3'd0, 3'd6, 4'd1}, 8'h00, 0, 6, 8'h00);
        run_n(3);
        in_valid = 4'h0; out_ready = 4'h0;
        #1;
        chk("prerst_ov", 64'(out_valid), 64'(4'b0001));
        #2;
        reset = 1;
        #1;
        chk("rst_ov", 64'(out_valid), 64'(0));
        chk("rst_state", 64'({busy_stall, stall_cycles, mov_data, out_data}), 64'(0));
        q.delete();
        m_mov = 8'h00; m_stall = 0;
        @(posedge clk); #1;
        reset = 0;
        chk("postrst_stall", 64'(stall_cycles), 64'(0));
        clear_obs();
        gen({8'h09, 3'd4, 3'd6, 4'd1}, 8'h00, 0, 0, 8'h00);
        run_all();
        chk("postrst_commit", 64'({pc_cyc, mov_at_pc}), 64'({32'd3, 8'h09}));

        for (int n = 0; n < 200; n++) begin
            op  = 4'($urandom_range(0, 15));
            src = 3'($urandom_range(0, 7));
            dst = (op == 4'd1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(4, 7));
            case ($urandom_range(0, 3))
                0:       acc = 8'h00;
                1:       acc = 8'h80;
                default: acc = 8'($urandom);
            endcase
            gen({8'($urandom), dst, src, op}, acc, $urandom_range(0, 3),
                $urandom_range(0, 3), 8'($urandom));
            run_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
